// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writer side of the program memory.
// Parses a framed byte stream, writes payload bytes into program RAM and
// holds the CPU in reset until a valid end-of-program frame is accepted.
//
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN data bytes, CHK.
// The 8-bit sum of ADDR_H..CHK must be zero. A frame with LEN=0 marks
// end-of-program.
//
// Ports
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_rx_data     incoming stream byte
//   i_rx_valid    i_rx_data valid this cycle
//   o_rx_ready    loader accepts a byte (transfer = valid & ready)
//   o_mem_we      program memory write strobe, one cycle per data byte
//   o_mem_addr    write address
//   o_mem_wdata   write data
//   o_cpu_hold    CPU held in reset while 1
//   o_busy        frame in progress
//   o_done        one-cycle pulse on an accepted end-of-program frame
//   o_err         sticky checksum/timeout error, cleared by the next SYNC
module prog_mem_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [7:0]        o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CHK, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          addr_h_q, addr_h_d;
  logic [7:0]          len_h_q, len_h_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         rem_q, rem_d;
  logic                is_end_q, is_end_d;
  logic [7:0]          sum_q, sum_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                rx_ready_q;
  logic                hold_q;
  logic                busy_q;

  logic                accept;
  logic                in_frame;
  logic [15:0]         len_full;
  logic [7:0]          sum_in;

  assign accept   = i_rx_valid & rx_ready_q;
  assign in_frame = (state_q != S_IDLE) && (state_q != S_DONE);
  assign len_full = {len_h_q, i_rx_data};
  assign sum_in   = sum_q + i_rx_data;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    addr_h_d = addr_h_q;
    len_h_d  = len_h_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    is_end_d = is_end_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    we_d     = 1'b0;
    maddr_d  = maddr_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;

    // Inter-byte timer: restarts on every accepted byte inside a frame
    if (in_frame) begin
      tmo_d = accept ? '0 : tmo_q + TMO_W'(1);
    end

    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (i_rx_data == SYNC_BYTE) begin
            state_d = S_ADDR_H;
            sum_d   = '0;
            err_d   = 1'b0;
            tmo_d   = '0;
          end
        end
        S_ADDR_H: begin
          addr_h_d = i_rx_data;
          sum_d    = sum_in;
          state_d  = S_ADDR_L;
        end
        S_ADDR_L: begin
          addr_d  = ADDR_W'({addr_h_q, i_rx_data});
          sum_d   = sum_in;
          state_d = S_LEN_H;
        end
        S_LEN_H: begin
          len_h_d = i_rx_data;
          sum_d   = sum_in;
          state_d = S_LEN_L;
        end
        S_LEN_L: begin
          rem_d    = len_full;
          is_end_d = (len_full == 16'h0000);
          sum_d    = sum_in;
          state_d  = (len_full == 16'h0000) ? S_CHK : S_DATA;
        end
        S_DATA: begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = i_rx_data;
          addr_d  = addr_q + ADDR_W'(1);
          rem_d   = rem_q - 16'd1;
          sum_d   = sum_in;
          if (rem_q == 16'd1) state_d = S_CHK;
        end
        S_CHK: begin
          sum_d = sum_in;
          if (sum_in == 8'h00) begin
            if (is_end_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: ;
      endcase
    end else if (in_frame && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      tmo_d   = '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_h_q   <= '0;
      len_h_q    <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      is_end_q   <= 1'b0;
      sum_q      <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      maddr_q    <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      rx_ready_q <= 1'b1;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_h_q   <= addr_h_d;
      len_h_q    <= len_h_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      is_end_q   <= is_end_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      we_q       <= we_d;
      maddr_q    <= maddr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      rx_ready_q <= (state_d != S_DONE);
      hold_q     <= (state_d != S_DONE);
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
    end
  end

  assign o_rx_ready  = rx_ready_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_wdata = wdata_q;
  assign o_cpu_hold  = hold_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: frame parsing, writes, checksum,
// address wrap, garbage rejection, timeout, reset abort, end-of-program.
module tb_prog_mem_loader;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned TIMEOUT = 20;

  logic              i_clk;
  logic              i_rst;
  logic [7:0]        i_rx_data;
  logic              i_rx_valid;
  logic              o_rx_ready;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        o_mem_wdata;
  logic              o_cpu_hold;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  int vectors;
  int miscompares;

  logic [7:0]        fq[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [7:0]        wr_data[$];
  int                done_cnt;

  prog_mem_loader #(
    .ADDR_W   (ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_rx_ready (o_rx_ready),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_cpu_hold (o_cpu_hold),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Record every write strobe and done pulse observed mid-cycle
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_mem_we) begin
        wr_addr.push_back(o_mem_addr);
        wr_data.push_back(o_mem_wdata);
      end
      if (o_done) done_cnt++;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
  endtask

  // Stream fq back-to-back, then drop valid and let the last write land
  task automatic send_fq();
    foreach (fq[i]) begin
      i_rx_valid = 1'b1;
      i_rx_data  = fq[i];
      @(posedge i_clk); #1;
    end
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    @(negedge i_clk); #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    do_reset();
    vectors += 8;
    if (o_rx_ready !== 1'b1) begin miscompares++; $display("FAIL reset rx_ready got %b want 1", o_rx_ready); end
    if (o_mem_we !== 1'b0) begin miscompares++; $display("FAIL reset mem_we got %b want 0", o_mem_we); end
    if (o_mem_addr !== 16'h0000) begin miscompares++; $display("FAIL reset mem_addr got %h want 0000", o_mem_addr); end
    if (o_mem_wdata !== 8'h00) begin miscompares++; $display("FAIL reset mem_wdata got %h want 00", o_mem_wdata); end
    if (o_cpu_hold !== 1'b1) begin miscompares++; $display("FAIL reset cpu_hold got %b want 1", o_cpu_hold); end
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b want 0", o_busy); end
    if (o_done !== 1'b0) begin miscompares++; $display("FAIL reset done got %b want 0", o_done); end
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL reset err got %b want 0", o_err); end
  endtask

  task automatic test_data_frame();
    clear_log();
    fq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBB};
    send_fq();
    vectors += 5;
    if (wr_addr.size() !== 2) begin
      miscompares++; $display("FAIL data_frame write_count got %0d want 2", wr_addr.size());
    end else begin
      if (wr_addr[0] !== 16'h0010 || wr_data[0] !== 8'h11) begin
        miscompares++; $display("FAIL data_frame wr0 got %h=%h want 0010=11", wr_addr[0], wr_data[0]);
      end
      if (wr_addr[1] !== 16'h0011 || wr_data[1] !== 8'h22) begin
        miscompares++; $display("FAIL data_frame wr1 got %h=%h want 0011=22", wr_addr[1], wr_data[1]);
      end
    end
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL data_frame err got %b want 0", o_err); end
    if (o_cpu_hold !== 1'b1 || o_busy !== 1'b0 || o_rx_ready !== 1'b1) begin
      miscompares++; $display("FAIL data_frame idle hold/busy/ready got %b%b%b want 101", o_cpu_hold, o_busy, o_rx_ready);
    end
  endtask

  task automatic test_bad_chk();
    clear_log();
    fq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBC};
    send_fq();
    vectors += 3;
    if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL bad_chk write_count got %0d want 2", wr_addr.size()); end
    if (o_err !== 1'b1) begin miscompares++; $display("FAIL bad_chk err got %b want 1", o_err); end
    if (o_cpu_hold !== 1'b1 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL bad_chk hold/busy got %b%b want 10", o_cpu_hold, o_busy);
    end
    // Resend: SYNC alone clears the sticky error
    fq = '{8'hA5};
    send_fq();
    vectors += 1;
    if (o_err !== 1'b0 || o_busy !== 1'b1) begin
      miscompares++; $display("FAIL bad_chk sync_clear err/busy got %b%b want 01", o_err, o_busy);
    end
    fq = '{8'h00, 8'h10, 8'h00, 8'h02, 8'h11, 8'h22, 8'hBB};
    send_fq();
    vectors += 1;
    if (o_err !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL bad_chk resend err/busy got %b%b want 00", o_err, o_busy);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    // FF+FF+00+02+AA+55 = 0x2FF, so CHK 01 closes the sum to zero
    fq = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h01};
    send_fq();
    vectors += 3;
    if (wr_addr.size() !== 2) begin
      miscompares++; $display("FAIL wrap write_count got %0d want 2", wr_addr.size());
    end else if (wr_addr[0] !== 16'hFFFF || wr_data[0] !== 8'hAA ||
                 wr_addr[1] !== 16'h0000 || wr_data[1] !== 8'h55) begin
      miscompares++; $display("FAIL wrap writes got %h=%h %h=%h want FFFF=AA 0000=55",
                              wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL wrap err got %b want 0", o_err); end
    // Same frame with CHK 03 does not sum to zero
    fq = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'h55, 8'h03};
    send_fq();
    if (o_err !== 1'b1) begin miscompares++; $display("FAIL wrap chk03 err got %b want 1", o_err); end
  endtask

  task automatic test_garbage();
    clear_log();
    fq = '{8'h00, 8'hFF, 8'h13};
    send_fq();
    vectors += 3;
    if (o_busy !== 1'b0 || wr_addr.size() !== 0) begin
      miscompares++; $display("FAIL garbage idle busy=%b writes=%0d want busy=0 writes=0", o_busy, wr_addr.size());
    end
    // 12+34+00+01+5A = 0xA1 -> CHK 5F
    fq = '{8'hA5, 8'h12, 8'h34, 8'h00, 8'h01, 8'h5A, 8'h5F};
    send_fq();
    if (wr_addr.size() !== 1) begin
      miscompares++; $display("FAIL garbage write_count got %0d want 1", wr_addr.size());
    end else if (wr_addr[0] !== 16'h1234 || wr_data[0] !== 8'h5A) begin
      miscompares++; $display("FAIL garbage wr0 got %h=%h want 1234=5A", wr_addr[0], wr_data[0]);
    end
    if (o_err !== 1'b0) begin miscompares++; $display("FAIL garbage err got %b want 0", o_err); end
  endtask

  task automatic test_timeout();
    clear_log();
    fq = '{8'hA5, 8'h00};
    send_fq();
    // one edge already elapsed inside send_fq; stay just short of the limit
    repeat (TIMEOUT - 3) @(posedge i_clk);
    #1;
    vectors += 3;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      miscompares++; $display("FAIL timeout early busy/err got %b%b want 10", o_busy, o_err);
    end
    repeat (4) @(posedge i_clk);
    #1;
    if (o_busy !== 1'b0 || o_err !== 1'b1) begin
      miscompares++; $display("FAIL timeout expired busy/err got %b%b want 01", o_busy, o_err);
    end
    if (wr_addr.size() !== 0) begin miscompares++; $display("FAIL timeout writes got %0d want 0", wr_addr.size()); end
  endtask

  task automatic test_rst_mid_data();
    clear_log();
    fq = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h04, 8'h01, 8'h02};
    send_fq();
    do_reset();
    @(negedge i_clk); #1;
    vectors += 3;
    if (wr_addr.size() !== 2) begin miscompares++; $display("FAIL rst_mid writes got %0d want 2", wr_addr.size()); end
    if (o_mem_addr !== 16'h0000 || o_mem_wdata !== 8'h00 || o_mem_we !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid mem we/addr/wdata got %b/%h/%h want 0/0000/00", o_mem_we, o_mem_addr, o_mem_wdata);
    end
    if (o_busy !== 1'b0 || o_err !== 1'b0 || o_cpu_hold !== 1'b1 || o_rx_ready !== 1'b1 || o_done !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid busy/err/hold/ready/done got %b%b%b%b%b want 00110",
                              o_busy, o_err, o_cpu_hold, o_rx_ready, o_done);
    end
  endtask

  task automatic test_end_frame();
    clear_log();
    fq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_fq();
    repeat (2) @(negedge i_clk);
    vectors += 4;
    if (done_cnt !== 1) begin miscompares++; $display("FAIL end_frame done_pulses got %0d want 1", done_cnt); end
    if (wr_addr.size() !== 0) begin miscompares++; $display("FAIL end_frame writes got %0d want 0", wr_addr.size()); end
    if (o_cpu_hold !== 1'b0 || o_rx_ready !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++; $display("FAIL end_frame hold/ready/busy got %b%b%b want 000", o_cpu_hold, o_rx_ready, o_busy);
    end
    // Bytes offered in DONE are dropped
    fq = '{8'hA5, 8'h00};
    send_fq();
    if (o_busy !== 1'b0 || o_cpu_hold !== 1'b0 || done_cnt !== 1) begin
      miscompares++; $display("FAIL end_frame ignore busy/hold/dones got %b%b%0d want 001", o_busy, o_cpu_hold, done_cnt);
    end
    do_reset();
    vectors += 1;
    if (o_cpu_hold !== 1'b1 || o_rx_ready !== 1'b1) begin
      miscompares++; $display("FAIL end_frame reset hold/ready got %b%b want 11", o_cpu_hold, o_rx_ready);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    i_rst       = 1'b1;
    i_rx_valid  = 1'b0;
    i_rx_data   = 8'h00;
    test_reset();
    test_data_frame();
    test_bad_chk();
    test_wrap();
    test_garbage();
    test_timeout();
    test_rst_mid_data();
    test_end_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
